// File: rtl/case9_resp_compactor_pkg.sv
// Shared definitions for the case9 response compactor:
// FSM states, response bit positions and default MISR constants.
package case9_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int RESP_W = 5;
    localparam int Y1_IDX = 0;
    localparam int Y2_IDX = 1;
    localparam int Y3_IDX = 2;
    localparam int Y4_IDX = 3;
    localparam int Y5_IDX = 4;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/case9_resp_compactor_if.sv
// Valid/ready response channel carrying y1..y5 from the netlist
// under test into the compactor.
interface case9_resp_compactor_if;
    import case9_pkg::*;

    logic              resp_valid;
    logic [RESP_W-1:0] resp;
    logic              resp_ready;

    modport master (
        output resp_valid,
        output resp,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp,
        output resp_ready
    );

endinterface

// File: rtl/case9_resp_compactor_misr_reg.sv
// Multiple-input signature register with a parallel data input,
// synchronous load of the seed and a shift enable.
module misr_reg #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'h1021),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] fb;

    always_comb begin
        fb    = sig_q[WIDTH-1] ? POLY : '0;
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (shift_en) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ fb ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/case9_resp_compactor.sv
// Compacts a programmed number of y1..y5 vectors into a MISR, flags
// any y2/y5 disagreement and compares the final signature to golden.
module case9_resp_compactor
    import case9_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
    parameter int               CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_pat,
    input  logic [SIG_W-1:0]       golden,
    case9_resp_compactor_if.slave  rsp,
    output logic [SIG_W-1:0]       sig,
    output logic [CNT_W-1:0]       count,
    output logic                   done,
    output logic                   pass,
    output logic                   eq_err
);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [CNT_W-1:0] num_pat_d, num_pat_q;
    logic [SIG_W-1:0] golden_d, golden_q;
    logic             eq_err_d, eq_err_q;
    logic [CNT_W-1:0] count_inc;
    logic             accept;
    logic [SIG_W-1:0] din;

    // start wins over a same-cycle handshake
    assign accept    = rsp.resp_valid & (state_q == RUN) & ~start;
    assign count_inc = count_q + CNT_W'(1);
    assign din       = {{(SIG_W-RESP_W){1'b0}}, rsp.resp};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        num_pat_d = num_pat_q;
        golden_d  = golden_q;
        eq_err_d  = eq_err_q;
        if (start) begin
            count_d   = '0;
            eq_err_d  = 1'b0;
            num_pat_d = num_pat;
            golden_d  = golden;
            state_d   = (num_pat != '0) ? RUN : DONE;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (accept) begin
                        count_d = count_inc;
                        if (rsp.resp[Y2_IDX] != rsp.resp[Y5_IDX]) begin
                            eq_err_d = 1'b1;
                        end
                        if (count_inc == num_pat_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            num_pat_q <= '0;
            golden_q  <= '0;
            eq_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            num_pat_q <= num_pat_d;
            golden_q  <= golden_d;
            eq_err_q  <= eq_err_d;
        end
    end

    misr_reg #(
        .WIDTH (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .shift_en (accept),
        .din      (din),
        .sig      (sig)
    );

    assign rsp.resp_ready = (state_q == RUN);
    assign count          = count_q;
    assign done           = (state_q == DONE);
    assign pass           = done & (sig == golden_q);
    assign eq_err         = eq_err_q;

endmodule

// File: tb/tb_case9_resp_compactor.sv
// Bench for case9_resp_compactor: run-level reference model checked
// every cycle, plus hand-computed expectations for the directed runs.
module tb_case9_resp_compactor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_pat;
    logic [15:0] golden;
    logic [15:0] sig, b_sig;
    logic [15:0] count, b_count;
    logic        done, b_done;
    logic        pass, b_pass;
    logic        eq_err, b_eq_err;

    int errs   = 0;
    int checks = 0;
    bit cmp_en = 0;

    case9_resp_compactor_if ifa ();
    case9_resp_compactor_if ifb ();

    assign ifb.resp_valid = ifa.resp_valid;
    assign ifb.resp       = ifa.resp;

    case9_resp_compactor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num_pat (num_pat),
        .golden  (golden),
        .rsp     (ifa),
        .sig     (sig),
        .count   (count),
        .done    (done),
        .pass    (pass),
        .eq_err  (eq_err)
    );

    case9_resp_compactor #(.SEED(16'h8000)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num_pat (num_pat),
        .golden  (golden),
        .rsp     (ifb),
        .sig     (b_sig),
        .count   (b_count),
        .done    (b_done),
        .pass    (b_pass),
        .eq_err  (b_eq_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Run-level model: a run is a list of accepted vectors folded
    // into a signature; the run ends once num_pat vectors were taken.
    logic [15:0] m_sig, m_gold, m_np, m_cnt;
    bit          m_run, m_done, m_eq;

    function automatic logic [15:0] fold(input logic [15:0] s,
                                         input logic [4:0] v);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0] ^ {11'd0, v};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sig = 0; m_gold = 0; m_np = 0; m_cnt = 0;
            m_run = 0; m_done = 0; m_eq = 0;
        end else if (start) begin
            m_sig = 0; m_cnt = 0; m_eq = 0;
            m_np = num_pat; m_gold = golden;
            m_run = (num_pat != 0);
            m_done = (num_pat == 0);
        end else if (m_run && ifa.resp_valid) begin
            m_sig = fold(m_sig, ifa.resp);
            m_cnt++;
            if (ifa.resp[1] != ifa.resp[4]) m_eq = 1;
            if (m_cnt == m_np) begin
                m_run = 0;
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("ready", ifa.resp_ready, m_run);
            chk("sig", sig, m_sig);
            chk("count", count, m_cnt);
            chk("done", done, m_done);
            chk("pass", pass, m_done && (m_sig == m_gold));
            chk("eq_err", eq_err, m_eq);
        end
    end

    task automatic do_start(input logic [15:0] np, input logic [15:0] g);
        start = 1; num_pat = np; golden = g;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send(input logic [4:0] v);
        ifa.resp_valid = 1; ifa.resp = v;
        @(negedge clk);
        ifa.resp_valid = 0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready"}, ifa.resp_ready, 0);
        chk({nm, "_sig"}, sig, 16'h0000);
        chk({nm, "_count"}, count, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_pass"}, pass, 0);
        chk({nm, "_eq"}, eq_err, 0);
    endtask

    logic [15:0] saved;

    initial begin
        rst_n = 0; start = 0; num_pat = 0; golden = 0;
        ifa.resp_valid = 0; ifa.resp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk_reset_vals("rst");
        chk("rst_b_sig", b_sig, 16'h8000);
        cmp_en = 1;

        do_start(1, 16'h0001);
        send(5'b00001);
        chk("t1_sig", sig, 16'h0001);
        chk("t1_count", count, 1);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_eq", eq_err, 0);
        chk("t1_ready", ifa.resp_ready, 0);

        do_start(2, 16'h0003);
        send(5'b00001);
        chk("t2_mid_done", done, 0);
        send(5'b00000);
        chk("t2_sig", sig, 16'h0002);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);

        do_start(1, 16'h1021);
        send(5'b00000);
        chk("t3_b_sig", b_sig, 16'h1021);
        chk("t3_b_done", b_done, 1);
        chk("t3_b_pass", b_pass, 1);
        chk("t3_sig", sig, 16'h0000);

        do_start(3, 16'h0000);
        send(5'b00000);
        chk("t4_eq0", eq_err, 0);
        send(5'b00010);
        chk("t4_eq1", eq_err, 1);
        send(5'b00000);
        chk("t4_done", done, 1);
        chk("t4_eq_hold", eq_err, 1);
        do_start(1, 16'h0000);
        chk("t4_eq_clr", eq_err, 0);
        chk("t4_cnt_clr", count, 0);
        send(5'b10010);
        chk("t4_eq_same", eq_err, 0);

        // start with a simultaneous valid vector must not absorb it
        do_start(4, 16'h0000);
        send(5'b00111);
        send(5'b01000);
        ifa.resp_valid = 1; ifa.resp = 5'h1f;
        do_start(2, 16'h0002);
        chk("t7_cnt0", count, 0);
        chk("t7_sig0", sig, 16'h0000);
        send(5'h03);
        send(5'h04);
        chk("t7_sig", sig, 16'h0002);
        chk("t7_pass", pass, 1);

        do_start(8, 16'h0000);
        for (int i = 0; i < 300 && !m_done; i++) begin
            ifa.resp_valid = 1'($urandom_range(0, 1));
            ifa.resp = 5'($urandom);
            @(negedge clk);
        end
        ifa.resp_valid = 0;
        chk("t5_done", done, 1);
        chk("t5_count", count, 8);
        chk("t5_ready", ifa.resp_ready, 0);
        saved = m_sig;
        for (int i = 0; i < 3; i++) send(5'(i + 5));
        chk("t5_hold", sig, saved);
        chk("t5_cnt_hold", count, 8);

        do_start(5, 16'h0000);
        send(5'b00011);
        send(5'b00101);
        send(5'b01001);
        chk("t6_cnt3", count, 3);
        #2 rst_n = 0;
        #1 chk_reset_vals("t6");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_start(0, 16'h0000);
        chk("t6_z_done", done, 1);
        chk("t6_z_sig", sig, 16'h0000);
        chk("t6_z_pass", pass, 1);
        chk("t6_z_ready", ifa.resp_ready, 0);
        chk("t6_b_sig", b_sig, 16'h8000);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
